// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl
//   Owns the program counter and the IF/ID pipeline register. Each cycle it
//   presents the PC to instruction memory and captures the returned word
//   into IF/ID. A flush redirects the PC and turns IF/ID into a bubble. A
//   stall holds the PC and/or IF/ID. Stall and flush cycles are counted.
//
// Ports
//   clk                - clock, all state updates on the rising edge
//   rst                - synchronous active-high reset
//   PCWrite_en_i       - 1: PC may advance, 0: hold PC
//   IF_ID_write_en_i   - 1: IF/ID may capture, 0: hold IF/ID
//   IF_ID_flush_i      - redirect PC to branch_target_i and kill IF/ID
//   branch_target_i    - redirect address (low two bits ignored)
//   imem_addr_o        - instruction memory address (current PC)
//   imem_rdata_i       - instruction at imem_addr_o, same cycle
//   IF_pc_o            - current PC
//   ID_pc_o            - PC of the instruction held in IF/ID
//   ID_pc_plus4_o      - ID_pc_o + 4 as captured
//   ID_instr_o         - instruction held in IF/ID
//   ID_valid_o         - 1: IF/ID holds a real instruction, 0: bubble
//   stall_count_o      - saturating count of stall cycles
//   flush_count_o      - saturating count of flush cycles
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite_en_i,
  input  logic        IF_ID_write_en_i,
  input  logic        IF_ID_flush_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] IF_pc_o,
  output logic [31:0] ID_pc_o,
  output logic [31:0] ID_pc_plus4_o,
  output logic [31:0] ID_instr_o,
  output logic        ID_valid_o,
  output logic [31:0] stall_count_o,
  output logic [31:0] flush_count_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  logic [31:0] pc_plus4;
  logic        stall_cycle;

  // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0.
  assign pc_plus4 = pc_q + 32'd4;

  // A flush cycle is never counted as a stall, even with PCWrite_en_i low.
  assign stall_cycle = !PCWrite_en_i && !IF_ID_flush_i;

  always_comb begin
    pc_d = pc_plus4;
    if (IF_ID_flush_i) begin
      pc_d = {branch_target_i[31:2], 2'b00};
    end else if (!PCWrite_en_i) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_instr_d    = id_instr_q;
    id_valid_d    = id_valid_q;
    if (IF_ID_flush_i) begin
      id_pc_d       = 32'd0;
      id_pc_plus4_d = 32'd0;
      id_instr_d    = NOP_INSTR;
      id_valid_d    = 1'b0;
    end else if (IF_ID_write_en_i) begin
      id_pc_d       = pc_q;
      id_pc_plus4_d = pc_plus4;
      id_instr_d    = imem_rdata_i;
      id_valid_d    = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_cycle && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (IF_ID_flush_i && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd0;
      id_instr_q    <= NOP_INSTR;
      id_valid_q    <= 1'b0;
      stall_cnt_q   <= 32'd0;
      flush_cnt_q   <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_instr_q    <= id_instr_d;
      id_valid_q    <= id_valid_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign IF_pc_o       = pc_q;
  assign ID_pc_o       = id_pc_q;
  assign ID_pc_plus4_o = id_pc_plus4_q;
  assign ID_instr_o    = id_instr_q;
  assign ID_valid_o    = id_valid_q;
  assign stall_count_o = stall_cnt_q;
  assign flush_count_o = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// tb_fetch_stage_ctrl
//   Directed bench for fetch_stage_ctrl. Instruction memory returns the
//   bitwise inverse of the address so each fetched word identifies its PC.
module tb_fetch_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        PCWrite_en_i;
  logic        IF_ID_write_en_i;
  logic        IF_ID_flush_i;
  logic [31:0] branch_target_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] IF_pc_o;
  logic [31:0] ID_pc_o;
  logic [31:0] ID_pc_plus4_o;
  logic [31:0] ID_instr_o;
  logic        ID_valid_o;
  logic [31:0] stall_count_o;
  logic [31:0] flush_count_o;

  int checks   = 0;
  int failures = 0;

  fetch_stage_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .PCWrite_en_i     (PCWrite_en_i),
    .IF_ID_write_en_i (IF_ID_write_en_i),
    .IF_ID_flush_i    (IF_ID_flush_i),
    .branch_target_i  (branch_target_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rdata_i     (imem_rdata_i),
    .IF_pc_o          (IF_pc_o),
    .ID_pc_o          (ID_pc_o),
    .ID_pc_plus4_o    (ID_pc_plus4_o),
    .ID_instr_o       (ID_instr_o),
    .ID_valid_o       (ID_valid_o),
    .stall_count_o    (stall_count_o),
    .flush_count_o    (flush_count_o)
  );

  assign imem_rdata_i = ~imem_addr_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic pcw, input logic ifw, input logic fl, input logic [31:0] bt);
    PCWrite_en_i     = pcw;
    IF_ID_write_en_i = ifw;
    IF_ID_flush_i    = fl;
    branch_target_i  = bt;
  endtask

  initial begin
    rst = 1'b1;
    set_ctl(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    step();

    // Reset state
    check("rst_pc",     IF_pc_o,       32'h0);
    check("rst_addr",   imem_addr_o,   32'h0);
    check("rst_instr",  ID_instr_o,    32'h0000_0013);
    check("rst_valid",  {31'd0, ID_valid_o}, 32'd0);
    check("rst_idpc",   ID_pc_o,       32'h0);
    check("rst_idpc4",  ID_pc_plus4_o, 32'h0);
    check("rst_stall",  stall_count_o, 32'd0);
    check("rst_flush",  flush_count_o, 32'd0);

    // Sequential fetch
    rst = 1'b0;
    check("seq_pc0", IF_pc_o, 32'h0);
    step();
    check("seq_pc4",    IF_pc_o,       32'h4);
    check("seq_idpc0",  ID_pc_o,       32'h0);
    check("seq_instr0", ID_instr_o,    ~32'h0);
    check("seq_idpc4",  ID_pc_plus4_o, 32'h4);
    check("seq_valid",  {31'd0, ID_valid_o}, 32'd1);
    step();
    check("seq_pc8",    IF_pc_o,       32'h8);
    check("seq_idpc_4", ID_pc_o,       32'h4);

    // Load-use stall at PC 0x8
    set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("stall_pc",    IF_pc_o,       32'h8);
    check("stall_idpc",  ID_pc_o,       32'h4);
    check("stall_instr", ID_instr_o,    ~32'h4);
    check("stall_cnt",   stall_count_o, 32'd1);
    set_ctl(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    check("unstall_pc",    IF_pc_o,    32'hC);
    check("unstall_idpc",  ID_pc_o,    32'h8);
    check("unstall_instr", ID_instr_o, ~32'h8);

    // Flush overrides stall
    set_ctl(1'b0, 1'b1, 1'b1, 32'h103);
    step();
    check("flush_pc",    IF_pc_o,       32'h100);
    check("flush_instr", ID_instr_o,    32'h0000_0013);
    check("flush_valid", {31'd0, ID_valid_o}, 32'd0);
    check("flush_idpc",  ID_pc_o,       32'h0);
    check("flush_idpc4", ID_pc_plus4_o, 32'h0);
    check("flush_cnt",   flush_count_o, 32'd1);
    check("flush_stall", stall_count_o, 32'd1);
    set_ctl(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    check("post_pc",    IF_pc_o,    32'h104);
    check("post_idpc",  ID_pc_o,    32'h100);
    check("post_valid", {31'd0, ID_valid_o}, 32'd1);

    // PC advances, IF/ID holds (fetched word dropped)
    set_ctl(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    check("drop_pc",    IF_pc_o,    32'h108);
    check("drop_idpc",  ID_pc_o,    32'h100);
    check("drop_instr", ID_instr_o, ~32'h100);

    // PC holds, IF/ID recaptures the same PC
    set_ctl(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    check("recap_pc",    IF_pc_o,       32'h108);
    check("recap_idpc",  ID_pc_o,       32'h108);
    check("recap_instr", ID_instr_o,    ~32'h108);
    check("recap_stall", stall_count_o, 32'd2);

    // Wrap at the top of the address space
    set_ctl(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    step();
    check("wrap_pc_top", IF_pc_o,       32'hFFFF_FFFC);
    check("wrap_flush",  flush_count_o, 32'd2);
    set_ctl(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    check("wrap_pc0",    IF_pc_o,       32'h0);
    check("wrap_idpc",   ID_pc_o,       32'hFFFF_FFFC);
    check("wrap_idpc4",  ID_pc_plus4_o, 32'h0);
    check("wrap_valid",  {31'd0, ID_valid_o}, 32'd1);

    // Run up to 0x20, then reset during a stall (flush also asserted)
    for (int i = 0; i < 8; i++) step();
    check("run_pc20", IF_pc_o, 32'h20);
    set_ctl(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("pre_rst_pc", IF_pc_o, 32'h20);
    rst = 1'b1;
    set_ctl(1'b0, 1'b0, 1'b1, 32'h200);
    #2;
    check("rst_sync_pc", IF_pc_o, 32'h20);
    step();
    check("mrst_pc",    IF_pc_o,       32'h0);
    check("mrst_instr", ID_instr_o,    32'h0000_0013);
    check("mrst_valid", {31'd0, ID_valid_o}, 32'd0);
    check("mrst_idpc",  ID_pc_o,       32'h0);
    check("mrst_stall", stall_count_o, 32'd0);
    check("mrst_flush", flush_count_o, 32'd0);
    rst = 1'b0;
    set_ctl(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    check("resume_pc",    IF_pc_o, 32'h4);
    check("resume_idpc",  ID_pc_o, 32'h0);
    check("resume_valid", {31'd0, ID_valid_o}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
